// File: rtl/pagerank_engine.sv
// Sequential Jacobi PageRank engine over an N-node graph in Q0.WIDTH, one adjacency element per clock.
// Define PAGERANK_EARLY_EXIT_EN to enable the EPS convergence exit and the converged flag.
module pagerank_engine #(
  parameter int          N        = 16,
  parameter int          WIDTH    = 16,
  parameter int unsigned D        = 32'h2666,
  parameter int unsigned EPS      = 32'h0004,
  parameter int          MAX_ITER = 64,
  parameter int          ITER_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N*N-1:0]       adjacency,
  input  logic [N*WIDTH-1:0]   weights,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [ITER_W-1:0]    iter_count,
  output logic [N*WIDTH-1:0]   ranks
);

  localparam int                IW        = $clog2(N);
  localparam logic [WIDTH:0]    BASE      = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]    DB        = BASE - (WIDTH+1)'(D);
  localparam logic [WIDTH-1:0]  DN        = WIDTH'(D / N);
  localparam logic [WIDTH-1:0]  INIT_RANK = WIDTH'(BASE >> IW);
  localparam logic [IW-1:0]     LAST      = IW'(N - 1);
  localparam logic [ITER_W-1:0] ITER_CAP  = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ACCUM, S_COMMIT, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] scale_weight(input logic [WIDTH-1:0] w);
    logic [2*WIDTH:0] p;
    p = (2*WIDTH+1)'(DB) * (2*WIDTH+1)'(w);
    return WIDTH'(p >> WIDTH);
  endfunction

  function automatic logic [WIDTH-1:0] mul_q(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    return WIDTH'(p >> WIDTH);
  endfunction

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic [IW-1:0]      r_q, k_q;
  logic [ITER_W-1:0]  iter_q;
  logic [WIDTH-1:0]   cur_q [N];
  logic [WIDTH-1:0]   nxt_q [N];
  logic [WIDTH-1:0]   wd_q  [N];
  logic [N*N-1:0]     adj_q;
  logic [WIDTH-1:0]   acc_q, acc_d, term;
  logic               row_end, last_elem, eps_hit, cap_hit, accept;

  assign accept    = (state_q == S_IDLE || state_q == S_DONE) && start;
  assign term      = mul_q(wd_q[k_q], cur_q[k_q]);
  assign acc_d     = (adj_q[{r_q, k_q}] && (r_q != k_q)) ? sat_add(acc_q, term) : acc_q;
  assign row_end   = (k_q == LAST);
  assign last_elem = row_end && (r_q == LAST);
  assign cap_hit   = (iter_q + 1'b1) == ITER_CAP;

`ifdef PAGERANK_EARLY_EXIT_EN
  logic               conv_q;
  logic [WIDTH-1:0]   maxdelta_q, row_delta;

  assign row_delta = (acc_d >= cur_q[r_q]) ? acc_d - cur_q[r_q] : cur_q[r_q] - acc_d;
  assign eps_hit   = (maxdelta_q <= WIDTH'(EPS));

  always_ff @(posedge clk) begin
    if (state_q == S_INIT || state_q == S_COMMIT)
      maxdelta_q <= '0;
    else if (state_q == S_ACCUM && row_end && row_delta > maxdelta_q)
      maxdelta_q <= row_delta;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conv_q <= 1'b0;
    else if (accept)
      conv_q <= 1'b0;
    else if (state_q == S_COMMIT)
      conv_q <= eps_hit;
  end

  assign converged = conv_q;
`else
  assign eps_hit   = 1'b0;
  assign converged = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_INIT;
      S_INIT:         state_d = S_ACCUM;
      S_ACCUM:        if (last_elem) state_d = S_COMMIT;
      S_COMMIT: begin
        if (eps_hit || cap_hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ACCUM;
        end
      end
      default:        state_d = S_IDLE;
    endcase
  end

  // control and committed ranks: r/k wrap to zero naturally because N is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      iter_q  <= '0;
      r_q     <= '0;
      k_q     <= '0;
      for (int i = 0; i < N; i++) cur_q[i] <= INIT_RANK;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      case (state_q)
        S_INIT: begin
          iter_q <= '0;
          r_q    <= '0;
          k_q    <= '0;
          for (int i = 0; i < N; i++) cur_q[i] <= INIT_RANK;
        end
        S_ACCUM: begin
          k_q <= k_q + 1'b1;
          if (row_end) r_q <= r_q + 1'b1;
        end
        S_COMMIT: begin
          iter_q <= iter_q + 1'b1;
          for (int i = 0; i < N; i++) cur_q[i] <= nxt_q[i];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          adj_q <= adjacency;
          for (int k = 0; k < N; k++) wd_q[k] <= scale_weight(weights[k*WIDTH +: WIDTH]);
        end
      end
      S_INIT: acc_q <= DN;
      S_ACCUM: begin
        if (row_end) begin
          nxt_q[r_q] <= acc_d;
          acc_q      <= DN;
        end else begin
          acc_q <= acc_d;
        end
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < N; g++) begin : g_ranks
    assign ranks[g*WIDTH +: WIDTH] = cur_q[g];
  end

  assign busy       = (state_q == S_INIT) || (state_q == S_ACCUM) || (state_q == S_COMMIT);
  assign done       = done_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_pagerank_engine.sv
// Directed bench for pagerank_engine (N=4, WIDTH=16) with a reference model feeding a scoreboard queue.
module tb_pagerank_engine;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 8;
`ifdef PAGERANK_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [N*W-1:0] ranks;
    int             iters;
    bit             conv;
    int             lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, start, sel;
  logic [N*N-1:0] adj;
  logic [N*W-1:0] wt;
  logic           st_a, st_b;
  logic           busy_a, done_a, conv_a, busy_b, done_b, conv_b;
  logic [IW-1:0]  it_a, it_b;
  logic [N*W-1:0] rk_a, rk_b;
  logic           o_busy, o_done, o_conv;
  logic [IW-1:0]  o_iter;
  logic [N*W-1:0] o_ranks;
  int             cyc = 0;
  int             total = 0;
  int             bad = 0;
  exp_t           sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign st_a    = start & ~sel;
  assign st_b    = start & sel;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;
  assign o_conv  = sel ? conv_b : conv_a;
  assign o_iter  = sel ? it_b   : it_a;
  assign o_ranks = sel ? rk_b   : rk_a;

  pagerank_engine #(.N(N), .WIDTH(W), .MAX_ITER(64), .ITER_W(IW)) dut_a (
    .clk(clk), .reset(rst), .start(st_a), .adjacency(adj), .weights(wt),
    .busy(busy_a), .done(done_a), .converged(conv_a), .iter_count(it_a), .ranks(rk_a));

  pagerank_engine #(.N(N), .WIDTH(W), .MAX_ITER(1), .ITER_W(IW)) dut_b (
    .clk(clk), .reset(rst), .start(st_b), .adjacency(adj), .weights(wt),
    .busy(busy_b), .done(done_b), .converged(conv_b), .iter_count(it_b), .ranks(rk_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N*N-1:0] a, input logic [N*W-1:0] w,
                                 input int max_iter, input bit early);
    exp_t   e;
    longint cur[N];
    longint nxt[N];
    longint wd[N];
    longint acc, md, d;
    int     it;
    bit     stop;
    for (int k = 0; k < N; k++) begin
      wd[k]  = ((65536 - 'h2666) * longint'(w[k*W +: W])) >> 16;
      cur[k] = 65536 / N;
    end
    it     = 0;
    e.conv = 1'b0;
    stop   = 1'b0;
    while (!stop) begin
      md = 0;
      for (int r = 0; r < N; r++) begin
        acc = 'h2666 / N;
        for (int k = 0; k < N; k++) begin
          if (a[r*N+k] && k != r) begin
            acc += (wd[k] * cur[k]) >> 16;
            if (acc > 65535) acc = 65535;
          end
        end
        nxt[r] = acc;
        d = (acc > cur[r]) ? acc - cur[r] : cur[r] - acc;
        if (d > md) md = d;
      end
      for (int i = 0; i < N; i++) cur[i] = nxt[i];
      it++;
      if (early && md <= 4) begin
        e.conv = 1'b1;
        stop   = 1'b1;
      end else if (it == max_iter) begin
        stop = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) e.ranks[i*W +: W] = W'(cur[i]);
    e.iters = it;
    e.lat   = 1 + it * (N*N + 1);
    return e;
  endfunction

  task automatic run(input string tag, input logic [N*N-1:0] a, input logic [N*W-1:0] w,
                     input int pulse_at);
    exp_t e;
    int   t0, n;
    bit   seen;
    @(negedge clk);
    adj   = a;
    wt    = w;
    start = 1'b1;
    sb.push_back(model(a, w, sel ? 1 : 64, EARLY));
    @(posedge clk); #1;
    t0    = cyc;
    start = 1'b0;
    adj   = ~a;
    wt    = {$urandom, $urandom};
    chk({tag, " busy_init"}, 64'(o_busy), 64'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(posedge clk); #1;
      n++;
      start = (n == pulse_at);
      if (n == 5) chk({tag, " ranks_mid_iter"}, o_ranks, {N{16'h4000}});
      if (o_done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    e = sb.pop_front();
    chk({tag, " latency"}, 64'(cyc - t0), 64'(e.lat));
    chk({tag, " ranks"}, o_ranks, e.ranks);
    chk({tag, " iter_count"}, 64'(o_iter), 64'(e.iters));
    chk({tag, " converged"}, 64'(o_conv), 64'(e.conv));
    chk({tag, " busy_at_done"}, 64'(o_busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    int dn;
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    adj   = '0;
    wt    = '0;
    @(posedge clk); #1;
    chk("reset ranks", rk_a, {N{16'h4000}});
    chk("reset busy", 64'(busy_a), 64'd0);
    chk("reset done", 64'(done_a), 64'd0);
    chk("reset conv", 64'(conv_a), 64'd0);
    chk("reset iter", 64'(it_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("empty", 16'h0000, {N{16'h5555}}, -1);
    chk("empty const ranks", o_ranks, {N{16'h0999}});
`ifdef PAGERANK_EARLY_EXIT_EN
    chk("empty const iter", 64'(o_iter), 64'd2);
    chk("empty const conv", 64'(o_conv), 64'd1);
`endif

    #2 rst = 1'b1;
    #1;
    chk("async reset ranks", rk_a, {N{16'h4000}});
    chk("async reset iter", 64'(it_a), 64'd0);
    chk("async reset conv", 64'(conv_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("complete", 16'h7BDE, {N{16'h5555}}, 5);
`ifdef PAGERANK_EARLY_EXIT_EN
    chk("complete const ranks", o_ranks, {N{16'h3FFF}});
    chk("complete const iter", 64'(o_iter), 64'd1);
`endif

    sel = 1'b1;
    run("star_cap", 16'h000E, {N{16'hFFFF}}, -1);
    chk("star const ranks", o_ranks, {16'h0999, 16'h0999, 16'h0999, 16'hACCB});
    chk("star const iter", 64'(o_iter), 64'd1);
    chk("star const conv", 64'(o_conv), 64'd0);
    sel = 1'b0;

    @(negedge clk);
    adj   = 16'h7BDE;
    wt    = {N{16'h5555}};
    start = 1'b1;
    sb.push_back(model(adj, wt, 64, EARLY));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort busy", 64'(busy_a), 64'd0);
    chk("abort done", 64'(done_a), 64'd0);
    chk("abort iter", 64'(it_a), 64'd0);
    chk("abort ranks", rk_a, {N{16'h4000}});
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    dn  = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done_a) dn++;
    end
    chk("abort no done pulse", 64'(dn), 64'd0);
    chk("abort stays idle", 64'(busy_a), 64'd0);

    run("rerun", 16'h7BDE, {N{16'h5555}}, -1);
`ifdef PAGERANK_EARLY_EXIT_EN
    chk("rerun const ranks", o_ranks, {N{16'h3FFF}});
`endif
    run("mixed", 16'h5A3C, {16'h4000, 16'hFFFF, 16'h5555, 16'h8000}, -1);

    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pagerank_engine.md
# pagerank_engine

Sequential, parametrised PageRank iteration engine for an N-node graph in unsigned Q0.WIDTH fixed point. It latches the adjacency matrix and per-node out-link weights on `start`, then runs Jacobi iterations with double-buffered rank storage, one matrix element per clock. It stops on convergence or after an iteration cap, and exposes all ranks plus status. It is the successor to the fixed 16-node combinational ranker and feeds the downstream rank sort stage.

## Interface
- `N`, 16: node count, power of two, 2..64
- `WIDTH`, 16: fixed-point width; value v represents v/2^WIDTH
- `D`, 16'h2666: damping term (0.15)
- `EPS`, 16'h0004: convergence threshold on max |delta|
- `MAX_ITER`, 64: iteration cap, 1..2^ITER_W-1
- `ITER_W`, 8: iteration counter width

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  start request, sampled in IDLE/DONE only
- `adjacency`  in  N*N  bit r*N+k = 1 means node k links to node r; diagonal ignored
- `weights`  in  N*WIDTH  slice k = 1/outdegree(k)
- `busy`  out  1  high from INIT through last COMMIT
- `done`  out  1  one-cycle pulse at run end
- `converged`  out  1  last run ended on EPS test; held until next start
- `iter_count`  out  ITER_W  iterations completed in current/last run
- `ranks`  out  N*WIDTH  committed rank of node i in slice i

## Operation
- Constants:
  - BASE = 2^WIDTH
  - DN = D/N (truncated)
  - DB = BASE-D
  - INIT_RANK = BASE/N
- FSM states: IDLE, INIT, ACCUM, COMMIT, DONE.
- IDLE/DONE with `start`=1:
  - latch `adjacency`
  - compute and register wd[k] = (DB*weights[k]) >> WIDTH
  - go to INIT
- INIT (1 cycle):
  - cur[i] = INIT_RANK
  - iter_count = 0
  - maxdelta = 0
  - r = k = 0
  - acc = DN
  - go to ACCUM
- ACCUM (N*N cycles), one (r,k) pair per cycle:
  - if adj[r*N+k] and k!=r: acc += (wd[k]*cur[k]) >> WIDTH
  - acc saturates at BASE-1
  - at k=N-1:
    - nxt[r] = acc
    - maxdelta = max(maxdelta, |acc-cur[r]|)
    - acc = DN, k = 0, r++
  - after r=N-1, k=N-1: go to COMMIT
- COMMIT (1 cycle):
  - cur = nxt
  - iter_count++
  - if maxdelta <= EPS: converged = 1, go to DONE
  - else if iter_count+1 == MAX_ITER: converged = 0, go to DONE
  - else: maxdelta = 0, r = k = 0, go to ACCUM
- DONE:
  - `done` pulses for one cycle
  - remains in DONE, ranks and status held, until `start`
- `start` in INIT/ACCUM/COMMIT is ignored; input changes mid-run have no effect.
- `ranks` always reflects cur. It changes only in INIT and COMMIT, never mid-iteration.
- Products are full width (2*WIDTH); all truncation is by right shift.

## Timing
- Reset values (immediate, asynchronous):
  - state = IDLE
  - `busy` = 0, `done` = 0, `converged` = 0
  - `iter_count` = 0
  - every rank slice = INIT_RANK
- Start accepted at edge t:
  - INIT is cycle t+1
  - iteration j ACCUM spans t+2+(j-1)(N²+1) .. t+1+j(N²+1)-1
  - iteration j COMMIT is cycle t+1+j(N²+1)
- Run ending after K iterations:
  - `done` = 1 and `busy` = 0 in cycle t+2+K(N²+1)
  - `ranks`, `iter_count` and `converged` are final in that same cycle
- Reset mid-run aborts immediately to reset values. No `done` pulse.
- `start` held high continuously re-arms from DONE in the cycle after the `done` pulse.

## Configuration
- `PAGERANK_EARLY_EXIT_EN` defined:
  - EPS test active as described
  - `converged` driven by the FSM
- Not defined:
  - EPS test removed
  - every run executes exactly MAX_ITER iterations
  - `converged` tied 0
  - maxdelta logic omitted

## Test plan
All cases use N=4, WIDTH=16, D=16'h2666, EPS=4, macro defined unless stated.

- **Reset:** assert `reset` asynchronously -> ranks all 16'h4000, busy/done/converged 0, iter_count 0, state IDLE before next edge.
- **Empty graph:** adjacency=0, start at t -> after iteration 1 all ranks 16'h0999. Iteration 2 delta 0 -> done at t+36, iter_count=2, converged=1.
- **Complete graph:** adjacency off-diagonal all 1, weights all 16'h5555 -> wd=18568, all ranks 16'h3FFF after iteration 1 (delta 1). Done at t+19, iter_count=1, converged=1.
- **Star, iteration cap:** node 0 fed by nodes 1..3, weights 16'hFFFF, MAX_ITER=1, macro undefined -> rank0=16'hACCB, ranks1..3=16'h0999, iter_count=1, converged=0, done at t+19.
- **Abort and ignore:**
  - `start` pulsed at cycle t+5 of a run -> ignored; timing unchanged.
  - `reset` at cycle t+10 -> reset values immediately, no done pulse.
  - Subsequent `start` -> full run with correct results.
